// File: rtl/logic_shift_pkg.sv
// +----------------------------------------------------------------------------+
// | logic_shift_pkg : op codes, op enum and FSM state type for logic_shift_unit |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package logic_shift_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SRA  = 4'd6,
    OP_ANDN = 4'd8,
    OP_ORN  = 4'd9,
    OP_XNOR = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bitwise_core.sv
// +----------------------------------------------------------------------------+
// | bitwise_core : combinational bitwise ops; ANDN/ORN/XNOR need LOGIC_SHIFT_NEGATE_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bitwise_core
  import logic_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
`ifdef LOGIC_SHIFT_NEGATE_EN
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      OP_XNOR: y = ~(a ^ b);
`endif
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/logic_shift_unit.sv
// +----------------------------------------------------------------------------+
// | logic_shift_unit : 1-cycle bitwise ops, iterative STEP-bit shifts; macro LOGIC_SHIFT_NEGATE_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module logic_shift_unit
  import logic_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int          AW     = $clog2(WIDTH);
  // One extra bit so STEP == WIDTH is representable.
  localparam logic [AW:0] STEP_C = (AW+1)'(STEP);

  state_e            state_q, state_d;
  logic [AW-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [OP_W-1:0]   sop_q, sop_d;

  logic [WIDTH-1:0]  w_core_y;
  logic [AW-1:0]     w_amt;
  logic [AW:0]       w_step;
  logic [AW-1:0]     w_rem_next;
  logic [WIDTH-1:0]  w_shifted;

  bitwise_core #(.WIDTH(WIDTH)) u_core (
    .a  (operand_a),
    .b  (operand_b),
    .op (op),
    .y  (w_core_y)
  );

  assign w_amt      = operand_b[AW-1:0];
  assign w_step     = ({1'b0, rem_q} < STEP_C) ? {1'b0, rem_q} : STEP_C;
  assign w_rem_next = rem_q - w_step[AW-1:0];

  always_comb begin
    w_shifted = res_q;
    case (sop_q)
      OP_SLL:  w_shifted = res_q << w_step;
      OP_SRL:  w_shifted = res_q >> w_step;
      default: w_shifted = WIDTH'($signed(res_q) >>> w_step);
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    res_d   = res_q;
    sop_d   = sop_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift(op)) begin
            res_d   = operand_a;
            rem_d   = w_amt;
            sop_d   = op;
            state_d = (w_amt == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            res_d   = w_core_y;
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        res_d = w_shifted;
        rem_d = w_rem_next;
        if (w_rem_next == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      res_q   <= '0;
      sop_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      sop_q   <= sop_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = res_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_shift_unit.sv
// +----------------------------------------------------------------------------+
// | tb_logic_shift_unit : directed bench for logic_shift_unit (WIDTH=32, STEP=4) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_logic_shift_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic_shift_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency, optionally stall in DONE, then consume.
  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] ia,
                     input logic [31:0] ib, input logic [31:0] exp, input int elat,
                     input int stall);
    int lat;
    @(negedge clk);
    op = o; operand_a = ia; operand_b = ib; in_valid = 1'b1;
    chk({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".result"}, result, exp);
    repeat (stall) begin
      @(posedge clk); #1;
      chk({tag, ".hold_result"}, result, exp);
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".ready_after"}, in_ready, 1);
    chk({tag, ".busy_after"}, busy, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 1);

    run("xor",    4'd2,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1, 0);
    run("sra9",   4'd6,  32'h80000000, 32'd9,        32'hFFC00000, 4, 0);
    run("sll0",   4'd4,  32'h12345678, 32'd0,        32'h12345678, 1, 0);
    run("op3",    4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0);
    run("op7",    4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0);
    run("op15",   4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0);
    run("and",    4'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1, 0);
    run("or",     4'd1,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1, 0);
    run("srl31",  4'd5,  32'h80000000, 32'd31,       32'h00000001, 9, 0);
    run("sll5",   4'd4,  32'h00000001, 32'd5,        32'h00000020, 3, 0);
    run("sra4p",  4'd6,  32'h70000000, 32'd4,        32'h07000000, 2, 0);
    run("srlhib", 4'd5,  32'hF0000000, 32'h00000124, 32'h0F000000, 2, 0);
    run("stall",  4'd2,  32'hA5A5A5A5, 32'h0000FFFF, 32'hA5A55A5A, 1, 5);
`ifdef LOGIC_SHIFT_NEGATE_EN
    run("andn",   4'd8,  32'h000000FF, 32'h0000000F, 32'h000000F0, 1, 0);
    run("orn",    4'd9,  32'h00000000, 32'hFFFFFFF0, 32'h0000000F, 1, 0);
    run("xnor",   4'd10, 32'hFFFF0000, 32'hFF00FF00, 32'hFF0000FF, 1, 0);
`else
    run("andn",   4'd8,  32'h000000FF, 32'h0000000F, 32'h00000000, 1, 0);
    run("orn",    4'd9,  32'h00000000, 32'hFFFFFFF0, 32'h00000000, 1, 0);
    run("xnor",   4'd10, 32'hFFFF0000, 32'hFF00FF00, 32'h00000000, 1, 0);
`endif

    // Reset during the second SHIFT cycle of a long SRL.
    @(negedge clk);
    op = 4'd5; operand_a = 32'hFFFFFFFF; operand_b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst.busy_before", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.in_ready", in_ready, 1);
    run("and_after_rst", 4'd0, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_shift_unit.md
LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and result width in bits (legal values: 8..64, power of two).
REQ-002 The block SHALL have parameter STEP, default 4, which sets the maximum shift distance per cycle (legal values: 1..WIDTH, power of two).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port op, input, 4 bits: operation code, per the package encoding.
REQ-008 The block SHALL have ports operand_a and operand_b, inputs, WIDTH bits each; the shift amount is operand_b[$clog2(WIDTH)-1:0].
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: operation result.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 Encoding SHALL be: AND=0, OR=1, XOR=2, SLL=4, SRL=5, SRA=6, ANDN=8, ORN=9, XNOR=10; every other code SHALL yield result 0 with normal 1-cycle latency.
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL equal (state==IDLE); a request is accepted on in_valid&&in_ready.
REQ-015 An accepted logical op or unsupported code SHALL capture its result and go to DONE, giving out_valid exactly 1 cycle after acceptance.
REQ-016 An accepted shift SHALL latch operand_a and the amount; amount 0 SHALL go straight to DONE with result=operand_a; otherwise the FSM SHALL go to SHIFT.
REQ-017 In SHIFT, each cycle SHALL shift by min(STEP, remaining) and decrement remaining by the same value; when remaining reaches 0 the FSM SHALL go to DONE.
REQ-018 Shift latency SHALL be 1+ceil(amount/STEP) cycles from acceptance to out_valid.
REQ-019 SRA SHALL replicate the MSB; SLL/SRL SHALL fill with zeros.
REQ-020 In DONE, out_valid=1 and result SHALL stay stable until out_ready; on out_valid&&out_ready the FSM SHALL return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-021 Operand changes while the FSM is not IDLE SHALL have no effect.

Reset
REQ-022 Asserting rst SHALL immediately force IDLE, out_valid=0, busy=0, result=0 and remaining=0, even mid-shift or with a result pending.
REQ-023 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-024 With macro LOGIC_SHIFT_NEGATE_EN defined, ANDN (a&~b), ORN (a|~b) and XNOR (~(a^b)) SHALL be supported.
REQ-025 Without LOGIC_SHIFT_NEGATE_EN, codes 8, 9 and 10 SHALL be treated as unsupported (result 0).

Structure
REQ-026 Package logic_shift_pkg SHALL hold the op enum typedef, the FSM state typedef and the op code constants.
REQ-027 The combinational bitwise function SHALL live in sub-module bitwise_core (inputs a, b, op; output y), instantiated once.

Verification
REQ-028 WIDTH=32: XOR, a=0xFFFF0000, b=0x0F0F0F0F -> result 0xF0F00F0F, with out_valid 1 cycle after acceptance.
REQ-029 STEP=4: SRA, a=0x80000000, amount 9 -> result 0xFFC00000, with out_valid 4 cycles after acceptance.
REQ-030 SLL, amount 0, a=0x12345678 -> result 0x12345678 after 1 cycle; op=3 -> result 0.
REQ-031 out_ready held low for 5 cycles in DONE -> result and out_valid stay stable and in_ready=0 throughout; handshake -> in_ready=1 next cycle.
REQ-032 rst asserted on the 2nd SHIFT cycle of SRL amount 31 -> out_valid=0, busy=0 and result=0 at once, and a new AND request is accepted after rst deasserts.
REQ-033 With the macro: ANDN, a=0xFF, b=0x0F -> 0xF0; without the macro: same stimulus -> 0.
